stb_arbiter: RTL and testbench

STB_ARBITER -- requirements
Module: stb_arbiter

---
 rtl/meas_pkg.sv | 18 +
 rtl/rr_pick.sv | 33 +++
 rtl/stb_arbiter.sv | 129 ++++++++++++
 tb/tb_stb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared definitions for the strobe arbiter: one-hot FSM encoding, default channel count
// and the round-robin pointer wrap helper.
package meas_pkg;

    localparam int DEFAULT_N_CH = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'b001,
        ST_ISSUE      = 3'b010,
        ST_WAIT_VALID = 3'b100
    } arb_state_t;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: finds the first set pending bit starting at rr_ptr_i
// and wrapping around the channel ring.
module rr_pick
    import meas_pkg::*;
#(
    parameter int N_CH = DEFAULT_N_CH
) (
    input  logic [N_CH-1:0]         pending_i,
    input  logic [$clog2(N_CH)-1:0] rr_ptr_i,
    output logic                    found_o,
    output logic [$clog2(N_CH)-1:0] index_o
);

    localparam int GW = $clog2(N_CH);

    always_comb begin
        int j;
        found_o = 1'b0;
        index_o = '0;
        // Walk from the farthest offset back to rr_ptr so the nearest hit is written last.
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = int'(rr_ptr_i) + k;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            if (pending_i[j]) begin
                found_o = 1'b1;
                index_o = GW'(j);
            end
        end
    end

endmodule

// File: rtl/stb_arbiter.sv
// Round-robin arbiter sharing one strobe generator among N_CH channel controllers.
// Define STB_ARB_TIMEOUT_EN to add the WAIT_VALID watchdog and sticky timeout_o flag.
module stb_arbiter
    import meas_pkg::*;
#(
    parameter int N_CH           = DEFAULT_N_CH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    en_i,
    input  logic [N_CH-1:0]         ch_stb_req_i,
    output logic [N_CH-1:0]         ch_stb_valid_o,
    output logic                    stb_req_o,
    input  logic                    stb_valid_i,
    output logic [$clog2(N_CH)-1:0] grant_id_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int GW = $clog2(N_CH);

    if (N_CH < 2 || N_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("stb_arbiter: N_CH must be 2..16 and TIMEOUT_CYCLES at least 1");
    end

    arb_state_t        r_state;
    logic [N_CH-1:0]   r_pending;
    logic [GW-1:0]     r_rr_ptr;
    logic [GW-1:0]     r_grant;
    logic [N_CH-1:0]   r_ch_valid;

    logic              w_found;
    logic [GW-1:0]     w_pick;
    logic [N_CH-1:0]   w_grant_onehot;
    logic [N_CH-1:0]   w_clear;
    logic [N_CH-1:0]   w_pending_next;
    logic [GW-1:0]     w_rr_next;
    logic              w_expire;

    rr_pick #(
        .N_CH (N_CH)
    ) u_rr_pick (
        .pending_i (r_pending),
        .rr_ptr_i  (r_rr_ptr),
        .found_o   (w_found),
        .index_o   (w_pick)
    );

    assign w_grant_onehot = {{(N_CH-1){1'b0}}, 1'b1} << r_grant;
    assign w_clear        = (r_state == ST_ISSUE) ? w_grant_onehot : '0;
    // A fresh request in the issue cycle is ORed in after the clear, so it survives.
    assign w_pending_next = (r_pending & ~w_clear) | ch_stb_req_i;
    assign w_rr_next      = GW'(wrap_inc(int'(r_grant), N_CH));

`ifdef STB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_watchdog;
    logic            r_timeout;

    assign w_expire = (r_state == ST_WAIT_VALID) && !stb_valid_i &&
                      (r_watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            r_watchdog <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_VALID && !stb_valid_i && !w_expire) begin
                r_watchdog <= r_watchdog + 1'b1;
            end else begin
                r_watchdog <= '0;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_ch_valid <= '0;
        end else begin
            r_pending  <= w_pending_next;
            r_ch_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (en_i && w_found) begin
                        r_state <= ST_ISSUE;
                        r_grant <= w_pick;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_VALID;
                end
                ST_WAIT_VALID: begin
                    if (stb_valid_i) begin
                        r_state    <= ST_IDLE;
                        r_ch_valid <= w_grant_onehot;
                        r_rr_ptr   <= w_rr_next;
                    end else if (w_expire) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stb_req_o      = (r_state == ST_ISSUE);
    assign busy_o         = (r_state != ST_IDLE);
    assign grant_id_o     = r_grant;
    assign ch_stb_valid_o = r_ch_valid;

endmodule

// File: tb/tb_stb_arbiter.sv
// Directed, table-driven bench for stb_arbiter plus hand-written latency and watchdog sequences.
// Build with STB_ARB_TIMEOUT_EN defined to include the watchdog sequence.
module tb_stb_arbiter;

    logic       clk;
    logic       arst;
    logic       en;
    logic [3:0] req;
    logic       valid;
    logic [3:0] ch_valid;
    logic       stb_req;
    logic [1:0] grant;
    logic       busy;
    logic       timeout;

    int n_vec  = 0;
    int n_miss = 0;

    stb_arbiter #(
        .N_CH           (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .en_i           (en),
        .ch_stb_req_i   (req),
        .ch_stb_valid_o (ch_valid),
        .stb_req_o      (stb_req),
        .stb_valid_i    (valid),
        .grant_id_o     (grant),
        .busy_o         (busy),
        .timeout_o      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs driven during one cycle, and the outputs expected in that same cycle.
    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] req;
        logic       valid;
        logic       e_stb;
        logic [1:0] e_gnt;
        logic [3:0] e_chv;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_n, input logic en_v, input logic [3:0] req_v,
                                input logic valid_v, input logic e_stb, input logic [1:0] e_gnt,
                                input logic [3:0] e_chv, input logic e_busy);
        vec_t v;
        v.rst_n = rst_n; v.en = en_v; v.req = req_v; v.valid = valid_v;
        v.e_stb = e_stb; v.e_gnt = e_gnt; v.e_chv = e_chv; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    initial begin
        int   n;
        logic seen_chv;

        arst = 1'b0; en = 1'b0; req = '0; valid = 1'b0;
        repeat (3) @(posedge clk);

        // Reset holds; request pulses during reset are dropped.
        add(0,1,4'b1111,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);
        // Single request on ch2 (cycle 0), stb_req at cycle 2, valid at cycle 5, done at 6.
        // Valid during ISSUE is ignored.
        add(1,1,4'b0100,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,1, 1,2,4'b0000,1);
        add(1,1,4'b0000,0, 0,2,4'b0000,1);
        add(1,1,4'b0000,0, 0,2,4'b0000,1);
        add(1,1,4'b0000,1, 0,2,4'b0000,1);
        add(1,1,4'b0000,0, 0,2,4'b0100,0);
        add(1,1,4'b0000,0, 0,2,4'b0000,0);
        // Reset, then all four channels at once: grants 0,1,2,3.
        add(0,1,4'b0000,0, 0,2,4'b0000,0);
        add(1,1,4'b1111,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 1,0,4'b0000,1);
        add(1,1,4'b0000,1, 0,0,4'b0000,1);
        add(1,1,4'b0000,0, 0,0,4'b0001,0);
        add(1,1,4'b0000,0, 1,1,4'b0000,1);
        add(1,1,4'b0000,1, 0,1,4'b0000,1);
        add(1,1,4'b0000,0, 0,1,4'b0010,0);
        add(1,1,4'b0000,0, 1,2,4'b0000,1);
        add(1,1,4'b0000,1, 0,2,4'b0000,1);
        add(1,1,4'b0000,0, 0,2,4'b0100,0);
        add(1,1,4'b0000,0, 1,3,4'b0000,1);
        add(1,1,4'b0000,1, 0,3,4'b0000,1);
        add(1,1,4'b0000,0, 0,3,4'b1000,0);
        // Valid while idle is ignored.
        add(1,1,4'b0000,1, 0,3,4'b0000,0);
        // ch1,2,3 pending; ch1 re-requests (with ch0) in its ISSUE cycle -> 1,2,3,0,1.
        add(1,1,4'b1110,0, 0,3,4'b0000,0);
        add(1,1,4'b0000,0, 0,3,4'b0000,0);
        add(1,1,4'b0011,0, 1,1,4'b0000,1);
        add(1,1,4'b0000,1, 0,1,4'b0000,1);
        add(1,1,4'b0000,0, 0,1,4'b0010,0);
        add(1,1,4'b0000,0, 1,2,4'b0000,1);
        add(1,1,4'b0000,1, 0,2,4'b0000,1);
        add(1,1,4'b0000,0, 0,2,4'b0100,0);
        add(1,1,4'b0000,0, 1,3,4'b0000,1);
        add(1,1,4'b0000,1, 0,3,4'b0000,1);
        add(1,1,4'b0000,0, 0,3,4'b1000,0);
        add(1,1,4'b0000,0, 1,0,4'b0000,1);
        add(1,1,4'b0000,1, 0,0,4'b0000,1);
        add(1,1,4'b0000,0, 0,0,4'b0001,0);
        add(1,1,4'b0000,0, 1,1,4'b0000,1);
        add(1,1,4'b0000,1, 0,1,4'b0000,1);
        // en_i drops in WAIT_VALID: transaction completes, pending ch3 waits for en_i.
        add(1,1,4'b0001,0, 0,1,4'b0010,0);
        add(1,1,4'b0000,0, 0,1,4'b0000,0);
        add(1,1,4'b1000,0, 1,0,4'b0000,1);
        add(1,0,4'b0000,0, 0,0,4'b0000,1);
        add(1,0,4'b0000,1, 0,0,4'b0000,1);
        add(1,0,4'b0000,0, 0,0,4'b0001,0);
        add(1,0,4'b0000,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 1,3,4'b0000,1);
        add(1,1,4'b0000,1, 0,3,4'b0000,1);
        // Reset in WAIT_VALID with pending 1010 clears everything.
        add(1,1,4'b1010,0, 0,3,4'b1000,0);
        add(1,1,4'b0000,0, 0,3,4'b0000,0);
        add(1,1,4'b0010,0, 1,1,4'b0000,1);
        add(0,1,4'b0000,0, 0,1,4'b0000,1);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);
        add(1,1,4'b0000,0, 0,0,4'b0000,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            n_vec++;
            if ({stb_req, grant, ch_valid, busy, timeout} !==
                {vecs[i].e_stb, vecs[i].e_gnt, vecs[i].e_chv, vecs[i].e_busy, 1'b0}) begin
                n_miss++;
                $display("FAIL vec %0d: got stb=%b gnt=%0d chv=%b busy=%b to=%b, expected stb=%b gnt=%0d chv=%b busy=%b to=0",
                         i, stb_req, grant, ch_valid, busy, timeout,
                         vecs[i].e_stb, vecs[i].e_gnt, vecs[i].e_chv, vecs[i].e_busy);
            end else begin
                $display("vec %0d: stb=%b gnt=%0d chv=%b busy=%b ok", i, stb_req, grant, ch_valid, busy);
            end
            arst  = vecs[i].rst_n;
            en    = vecs[i].en;
            req   = vecs[i].req;
            valid = vecs[i].valid;
        end

        // Latency: request ch1, stb_req_o expected exactly two cycles later.
        @(negedge clk);
        arst = 1'b1; en = 1'b1; valid = 1'b0; req = 4'b0010;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req = '0;
            if (stb_req) begin
                n = c;
                break;
            end
        end
        check("req_to_stb_latency", n, 2);
        check("latency_grant", grant, 1);
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("latency_chv", {stb_req, ch_valid}, {1'b0, 4'b0010});

`ifdef STB_ARB_TIMEOUT_EN
        // Watchdog: ch2 granted, no valid -> 8 WAIT_VALID cycles, then idle with timeout set.
        @(negedge clk);
        req = 4'b0100;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req = '0;
            if (stb_req) begin
                n = c;
                break;
            end
        end
        check("to_issue_latency", n, 2);
        check("to_grant", grant, 2);
        n = 0;
        seen_chv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ch_valid != '0) seen_chv = 1'b1;
            if (!busy) break;
            n++;
        end
        check("to_wait_cycles", n, 8);
        check("to_no_chv", seen_chv, 0);
        check("to_flag", timeout, 1);
        // Pointer advanced past ch2: ch3 beats ch0.
        req = 4'b1001;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("to_rr_advance", {stb_req, grant}, {1'b1, 2'd3});
`else
        seen_chv = 1'b0;
        check("no_timeout_flag", {seen_chv, timeout}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
